// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               controller state encoding and bit-counter width helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package mult_seq_pkg;

    // Controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH_B itself.
    function automatic int cnt_width(input int wb);
        return $clog2(wb + 1);
    endfunction

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Control FSM for the sequential multiplier. Accepts a start
//               request while idle, counts WIDTH_B compute cycles, then
//               spends one cycle in FINISH where the product is written.
// Ports       : clk      - clock, rising edge
//               reset_a  - synchronous active-high reset
//               i_start  - operation request (level, sampled while idle)
//               o_busy   - registered, high from acceptance until done
//               o_done   - registered one-cycle completion pulse
//               o_load   - datapath strobe: latch operands this edge
//               o_step   - datapath strobe: one shift-add step this edge
//               o_finish - datapath strobe: write product this edge
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH_B = 8
) (
    input  logic clk,
    input  logic reset_a,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    output logic o_load,
    output logic o_step,
    output logic o_finish
);

    localparam int                 c_CNT_W = cnt_width(WIDTH_B);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH_B - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + c_ONE;
                    // The edge that processes the last multiplier bit
                    // also moves on to FINISH.
                    if (r_cnt == c_LAST) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes decode the registered state so the datapath updates on the
    // same edge as the state transition they belong to. Start is only
    // looked at in IDLE, so requests while busy are simply dropped.
    assign o_load   = (r_state == IDLE) && i_start;
    assign o_step   = (r_state == CALC);
    assign o_finish = (r_state == FINISH);
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule : mult_seq_ctrl
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_param
// Description : Parametrised sequential shift-add multiplier, one multiplier
//               bit per clock, signed or unsigned per operation. Signed
//               operands are reduced to magnitudes and the sign reapplied
//               after accumulation.
// Ports       : clk          - clock, rising edge
//               reset_a      - synchronous active-high reset
//               dataa        - multiplicand, sampled on accepted start
//               datab        - multiplier, sampled on accepted start
//               mode_signed  - 1 = two's complement, 0 = unsigned
//               start        - request, accepted while idle
//               busy         - operation in progress
//               product_out  - held result, updated on each done
//               done_flag    - one-cycle pulse, product_out valid
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mult_seq_param
    import mult_seq_pkg::*;
#(
    parameter  int WIDTH_A = 8,
    parameter  int WIDTH_B = 8,
    localparam int PW      = WIDTH_A + WIDTH_B
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic [WIDTH_A-1:0] dataa,
    input  logic [WIDTH_B-1:0] datab,
    input  logic               mode_signed,
    input  logic               start,
    output logic               busy,
    output logic [PW-1:0]      product_out,
    output logic               done_flag
);

    logic w_load;
    logic w_step;
    logic w_finish;

    mult_seq_ctrl #(
        .WIDTH_B (WIDTH_B)
    ) u_ctrl (
        .clk      (clk),
        .reset_a  (reset_a),
        .i_start  (start),
        .o_busy   (busy),
        .o_done   (done_flag),
        .o_load   (w_load),
        .o_step   (w_step),
        .o_finish (w_finish)
    );

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly its magnitude 2^(W-1).
    logic [WIDTH_A-1:0] w_abs_a;
    logic [WIDTH_B-1:0] w_abs_b;
    logic               w_neg;

    always_comb begin
        w_abs_a = (mode_signed && dataa[WIDTH_A-1]) ? -dataa : dataa;
        w_abs_b = (mode_signed && datab[WIDTH_B-1]) ? -datab : datab;
        w_neg   = mode_signed && (dataa[WIDTH_A-1] ^ datab[WIDTH_B-1]);
    end

    logic [PW-1:0]      r_mcand;   // multiplicand, shifted left each step
    logic [WIDTH_B-1:0] r_mplier;  // multiplier, LSB is the current bit
    logic [PW-1:0]      r_acc;
    logic               r_neg;
    logic [PW-1:0]      r_product;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_load) begin
            r_mcand  <= {{WIDTH_B{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_neg    <= w_neg;
        end else if (w_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end else if (w_finish) begin
            r_product <= r_neg ? -r_acc : r_acc;
        end
    end

    assign product_out = r_product;

endmodule : mult_seq_param
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_param
// Description : Self-checking bench for mult_seq_param. Default 8x8 instance
//               plus a 12x4 instance, results compared against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default 8x8 instance
    logic        reset_a, start, mode_signed, busy, done_flag;
    logic [7:0]  dataa, datab;
    logic [15:0] product_out;

    // 12x4 instance
    logic        reset_v, start_v, mode_v, busy_v, done_v;
    logic [11:0] dataa_v;
    logic [3:0]  datab_v;
    logic [15:0] product_v;

    int n_pass  = 0;
    int n_total = 0;

    mult_seq_param #(.WIDTH_A(8), .WIDTH_B(8)) dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .dataa       (dataa),
        .datab       (datab),
        .mode_signed (mode_signed),
        .start       (start),
        .busy        (busy),
        .product_out (product_out),
        .done_flag   (done_flag)
    );

    mult_seq_param #(.WIDTH_A(12), .WIDTH_B(4)) dut_v (
        .clk         (clk),
        .reset_a     (reset_v),
        .dataa       (dataa_v),
        .datab       (datab_v),
        .mode_signed (mode_v),
        .start       (start_v),
        .busy        (busy_v),
        .product_out (product_v),
        .done_flag   (done_v)
    );

    // Reference model: interpret operands as integers and multiply.
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y, p;
        x = longint'(a);
        y = longint'(b);
        if (s && x >= 128) x = x - 256;
        if (s && y >= 128) y = y - 256;
        p = x * y;
        return 16'(p);
    endfunction

    function automatic logic [15:0] model_v(input logic [11:0] a, input logic [3:0] b, input logic s);
        longint x, y, p;
        x = longint'(a);
        y = longint'(b);
        if (s && x >= 2048) x = x - 4096;
        if (s && y >= 8) y = y - 16;
        p = x * y;
        return 16'(p);
    endfunction

    // Stimulus driver: issue one operation, scramble the inputs after
    // acceptance, wait (bounded) for done. lat counts edges after acceptance.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] p, output int lat, output int bcnt);
        dataa = a; datab = b; mode_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dataa = 8'($urandom); datab = 8'($urandom); mode_signed = 1'($urandom);
        bcnt = (busy === 1'b1) ? 1 : 0;
        lat  = 0;
        while (done_flag !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        p = product_out;
    endtask

    task automatic opv(input logic [11:0] a, input logic [3:0] b, input logic s,
                       output logic [15:0] p, output int lat);
        dataa_v = a; datab_v = b; mode_v = s; start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        dataa_v = 12'($urandom); datab_v = 4'($urandom); mode_v = 1'($urandom);
        lat = 0;
        while (done_v !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = product_v;
    endtask

    task automatic test_reset;
        reset_a = 1'b1; reset_v = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done_flag !== 1'b0) $display("FAIL reset_done: got %b want 0", done_flag); else n_pass++;
        n_total++; if (product_out !== 16'h0) $display("FAIL reset_product: got %h want 0000", product_out); else n_pass++;
        n_total++; if (busy_v !== 1'b0) $display("FAIL reset_busy_v: got %b want 0", busy_v); else n_pass++;
        n_total++; if (done_v !== 1'b0) $display("FAIL reset_done_v: got %b want 0", done_v); else n_pass++;
        n_total++; if (product_v !== 16'h0) $display("FAIL reset_product_v: got %h want 0000", product_v); else n_pass++;
        reset_a = 1'b0; reset_v = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        logic [15:0] p, exp;
        int lat, bc;
        op8(8'd17, 8'd100, 1'b0, p, lat, bc);
        exp = model8(8'd17, 8'd100, 1'b0);
        n_total++; if (p !== exp) $display("FAIL unsigned_17x100: got %h want %h", p, exp); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL unsigned_latency: got %0d want 9", lat); else n_pass++;
        n_total++; if (bc !== 9) $display("FAIL unsigned_busy_cycles: got %0d want 9", bc); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done_flag !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done_flag); else n_pass++;
        n_total++; if (product_out !== exp) $display("FAIL product_held: got %h want %h", product_out, exp); else n_pass++;
        op8(8'd255, 8'd255, 1'b0, p, lat, bc);
        exp = model8(8'd255, 8'd255, 1'b0);
        n_total++; if (p !== exp) $display("FAIL unsigned_255x255: got %h want %h", p, exp); else n_pass++;
    endtask

    task automatic test_signed;
        logic [7:0] a_tab [4] = '{8'hFF, 8'h80, 8'h80, 8'h80};
        logic [7:0] b_tab [4] = '{8'hFF, 8'h7F, 8'h80, 8'h00};
        logic [15:0] p, exp;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            op8(a_tab[i], b_tab[i], 1'b1, p, lat, bc);
            exp = model8(a_tab[i], b_tab[i], 1'b1);
            n_total++; if (p !== exp) $display("FAIL signed_%h_x_%h: got %h want %h", a_tab[i], b_tab[i], p, exp); else n_pass++;
            n_total++; if (lat !== 9) $display("FAIL signed_latency_%0d: got %0d want 9", i, lat); else n_pass++;
        end
    endtask

    task automatic test_start_while_busy;
        logic [15:0] prev, exp;
        int lat;
        prev = product_out;
        exp  = model8(8'd94, 8'd57, 1'b0);
        dataa = 8'd94; datab = 8'd57; mode_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        dataa = 8'd14; datab = 8'd7; mode_signed = 1'b1; start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        n_total++; if (product_out !== prev) $display("FAIL busy_product_untouched: got %h want %h", product_out, prev); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_during_calc: got %b want 1", busy); else n_pass++;
        while (done_flag !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_total++; if (product_out !== exp) $display("FAIL ignored_start_product: got %h want %h", product_out, exp); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL ignored_start_latency: got %0d want 9", lat); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (product_out !== exp) $display("FAIL hold_after_done: got %h want %h", product_out, exp); else n_pass++;
        n_total++; if (busy !== 1'b0 || done_flag !== 1'b0) $display("FAIL no_queued_request: got busy=%b done=%b want 0 0", busy, done_flag); else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        logic [15:0] p, exp;
        int lat, bc, dones;
        dataa = 8'd32; datab = 8'd232; mode_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        reset_a = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (product_out !== 16'h0) $display("FAIL midreset_product: got %h want 0000", product_out); else n_pass++;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_flag === 1'b1) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", dones); else n_pass++;
        op8(8'd14, 8'd7, 1'b0, p, lat, bc);
        exp = model8(8'd14, 8'd7, 1'b0);
        n_total++; if (p !== exp) $display("FAIL after_reset_14x7: got %h want %h", p, exp); else n_pass++;
        n_total++; if (lat !== 9) $display("FAIL after_reset_latency: got %0d want 9", lat); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp, p1, p2;
        int t1, t2, guard;
        logic bchk;
        exp = model8(8'd26, 8'd100, 1'b0);
        t1 = -1; t2 = -1; guard = 0; bchk = 1'b0; p1 = '0; p2 = '0;
        dataa = 8'd26; datab = 8'd100; mode_signed = 1'b0; start = 1'b1;
        while (t2 < 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
            if (t1 >= 0 && guard == t1 + 1) bchk = busy;
            if (done_flag === 1'b1) begin
                if (t1 < 0) begin
                    t1 = guard; p1 = product_out;
                end else begin
                    t2 = guard; p2 = product_out; start = 1'b0;
                end
            end
        end
        n_total++; if (t1 !== 10) $display("FAIL b2b_first_latency: got %0d want 10", t1); else n_pass++;
        n_total++; if (t2 - t1 !== 10) $display("FAIL b2b_spacing: got %0d want 10", t2 - t1); else n_pass++;
        n_total++; if (bchk !== 1'b1) $display("FAIL b2b_reaccept: got busy=%b want 1", bchk); else n_pass++;
        n_total++; if (p1 !== exp) $display("FAIL b2b_product1: got %h want %h", p1, exp); else n_pass++;
        n_total++; if (p2 !== exp) $display("FAIL b2b_product2: got %h want %h", p2, exp); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_random;
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] p, exp;
        int lat, bc;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            if (i == 0) a = 8'h00;
            op8(a, b, s, p, lat, bc);
            exp = model8(a, b, s);
            n_total++; if (p !== exp || lat !== 9) $display("FAIL random_%0d: %h*%h s=%b got %h lat %0d want %h lat 9", i, a, b, s, p, lat, exp); else n_pass++;
        end
    endtask

    task automatic test_variant;
        logic [11:0] a;
        logic [3:0]  b;
        logic        s;
        logic [15:0] p, exp;
        int lat;
        opv(12'd4095, 4'd15, 1'b0, p, lat);
        exp = model_v(12'd4095, 4'd15, 1'b0);
        n_total++; if (p !== exp) $display("FAIL v_unsigned_max: got %h want %h", p, exp); else n_pass++;
        n_total++; if (lat !== 5) $display("FAIL v_latency: got %0d want 5", lat); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done_v !== 1'b0) $display("FAIL v_done_one_cycle: got %b want 0", done_v); else n_pass++;
        opv(12'h800, 4'h8, 1'b1, p, lat);
        exp = model_v(12'h800, 4'h8, 1'b1);
        n_total++; if (p !== exp) $display("FAIL v_signed_min: got %h want %h", p, exp); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            a = 12'($urandom); b = 4'($urandom); s = 1'($urandom);
            opv(a, b, s, p, lat);
            exp = model_v(a, b, s);
            n_total++; if (p !== exp || lat !== 5) $display("FAIL v_random_%0d: %h*%h s=%b got %h lat %0d want %h lat 5", i, a, b, s, p, lat, exp); else n_pass++;
        end
    endtask

    initial begin
        reset_a = 1'b1; start = 1'b0; mode_signed = 1'b0; dataa = '0; datab = '0;
        reset_v = 1'b1; start_v = 1'b0; mode_v = 1'b0; dataa_v = '0; datab_v = '0;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        test_variant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult_seq_param
`default_nettype wire

// File: doc/mult_seq_param.md
Name: mult_seq_param

Overview:
Parametrised sequential shift-add multiplier, next generation of the team's 8x8 sequential multiplier. It takes WIDTH_A x WIDTH_B operands on a start pulse and processes one multiplier bit per clock. It supports signed (two's complement) and unsigned modes, selected per operation. It provides a busy flag, defined handling of start while busy, and a one-cycle done pulse with a held product. It sits as a low-area arithmetic unit beside the control datapath, where a combinational multiplier is too large.

Parameters:
WIDTH_A, 8, multiplicand width in bits (>=2)
WIDTH_B, 8, multiplier width in bits (>=2); also sets the number of compute cycles
PW, WIDTH_A+WIDTH_B, product width (derived, not overridable)

Ports:
clk  input  1  single clock, all logic on rising edge
reset_a  input  1  synchronous, active-high reset
dataa  input  WIDTH_A  multiplicand, sampled only on an accepted start
datab  input  WIDTH_B  multiplier, sampled only on an accepted start
mode_signed  input  1  1 = two's complement operands, 0 = unsigned; sampled with start
start  input  1  request; accepted on a rising edge when the block is idle
busy  output  1  high from the edge after acceptance until done_flag is raised
product_out  output  PW  result register; holds its value until the next done
done_flag  output  1  one-cycle pulse, product_out valid in the same cycle

Behaviour:
- Reset (reset_a=1 at an edge) has priority over everything.
  - Clears state to IDLE, busy=0, done_flag=0, product_out=0, and counter, accumulator and operand registers to 0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, CALC, FINISH.
- IDLE: start=1 at edge E0 means accept.
  - Latch |dataa| and |datab| (magnitudes when mode_signed=1, raw values otherwise).
  - Latch sign flag neg = mode_signed & (dataa[MSB] ^ datab[MSB]).
  - Clear accumulator, set count=0, go to CALC, busy=1.
- CALC: each edge adds the shifted multiplicand to the accumulator if the current multiplier bit is 1, shifts, and increments count.
  - After WIDTH_B edges (E1..E_WIDTH_B), go to FINISH.
- FINISH (edge E_WIDTH_B+1):
  - product_out = neg ? -acc : acc, truncated to PW bits.
  - done_flag=1, busy=0, state returns to IDLE.
- Latency: done_flag high in the cycle after edge E0+WIDTH_B+1, i.e. WIDTH_B+1 cycles after start is sampled (9 cycles at default).
- done_flag deasserts at the next edge. product_out is unchanged until the next FINISH; it is not cleared by a new start.
- start while busy (CALC/FINISH) is ignored. Operands, mode and product_out are unaffected and no request is queued.
- start held high is treated level-wise: re-accepted at the first idle edge, including the edge right after done. Back-to-back throughput is one result per WIDTH_B+2 cycles.
- Width rules:
  - Internal magnitudes use WIDTH_A/WIDTH_B bits unsigned. The most negative value's magnitude, 2^(W-1), fits.
  - The accumulator is PW bits.
  - Full-range results fit exactly: unsigned max (2^A-1)(2^B-1); signed max (-2^(A-1))*(-2^(B-1)) = 2^(A+B-2).
- Zero operands still take the full latency; there is no early termination.
- Counter width: $clog2(WIDTH_B+1).

Decomposition:
- Shared package mult_seq_pkg: state enum (IDLE, CALC, FINISH), and a function computing the counter width from WIDTH_B.
- One sub-module: mult_seq_ctrl, containing the FSM, bit counter, start-accept and busy/done generation.
- The datapath (abs, shift-add, final negate) stays in the top module.

Test Plan:
1. Unsigned default widths: dataa=17, datab=100, start one cycle -> busy for 9 cycles, then done_flag one cycle with product_out=1700 (0x06A4). 255*255 -> 0xFE01.
2. Signed mode: 0xFF*0xFF -> 0x0001; 0x80*0x7F -> 0xC080 (-16256); 0x80*0x80 -> 0x4000; 0x80*0x00 -> 0x0000.
3. Start while busy: 94*57 accepted; on cycle 3, start=1 with dataa=14, datab=7 -> ignored; done gives 5358 (0x14EE) at the original latency. product_out stays 5358 until the next done.
4. Reset mid-operation: 32*232 started, reset_a=1 on cycle 4 -> busy=0, product_out=0, no done. Then 14*7 -> 98 after 9 cycles.
5. Back-to-back: start held high across done -> second operation accepted the edge after done. Done pulses exactly 10 cycles apart, each product correct (26*100=2600).
6. Parameter variant WIDTH_A=12, WIDTH_B=4: unsigned 4095*15 -> 61425 with latency 5 cycles; signed 0x800*0x8 -> 0x4000.
